// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Owns the PC, reads instruction memory combinationally and
//               hands {pc, instr} pairs to decode through a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int c_BOOT_W = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [c_BOOT_W-1:0] c_BOOT_INIT = c_BOOT_W'(BOOT_CYCLES);
    localparam logic [c_BOOT_W-1:0] c_BOOT_ONE  = c_BOOT_W'(1);

    localparam logic [0:0] c_ST_BOOT  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;
    localparam logic [0:0] c_ST_RESET = (BOOT_CYCLES == 0) ? c_ST_RUN : c_ST_BOOT;

    logic [31:0]         r_pc;
    logic [1:0]          r_count;
    logic [0:0]          r_state;
    logic [c_BOOT_W-1:0] r_boot_cnt;
    logic [31:0]         r_buf_pc    [2];
    logic [31:0]         r_buf_instr [2];

    logic        w_pop;
    logic        w_fetch;
    logic        w_tail;
    logic [31:0] w_target;

    assign w_pop    = (r_count != 2'd0) && out_ready;
    assign w_fetch  = (r_state == c_ST_RUN) && !redirect_valid &&
                      ((r_count < 2'd2) || w_pop);
    // Slot index for the incoming entry, after accounting for a same-cycle pop
    assign w_tail   = r_count[1] | (r_count[0] & ~w_pop);
    assign w_target = redirect_target & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_count    <= 2'd0;
            r_state    <= c_ST_RESET;
            r_boot_cnt <= c_BOOT_INIT;
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]    <= 32'd0;
                r_buf_instr[i] <= 32'd0;
            end
        end else begin
            if (r_state == c_ST_BOOT) begin
                if (r_boot_cnt <= c_BOOT_ONE) begin
                    r_state    <= c_ST_RUN;
                    r_boot_cnt <= '0;
                end else begin
                    r_boot_cnt <= r_boot_cnt - c_BOOT_ONE;
                end
            end

            if (redirect_valid) begin
                r_pc    <= w_target;
                r_count <= 2'd0;
            end else begin
                r_count <= r_count + {1'b0, w_fetch} - {1'b0, w_pop};
                if (w_pop) begin
                    r_buf_pc[0]    <= r_buf_pc[1];
                    r_buf_instr[0] <= r_buf_instr[1];
                end
                // A push into slot 0 overrides the shift above
                if (w_fetch) begin
                    r_pc                <= r_pc + 32'd4;
                    r_buf_pc[w_tail]    <= r_pc;
                    r_buf_instr[w_tail] <= imem_data;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = r_buf_pc[0];
    assign out_instr = r_buf_instr[0];

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V 32-bit single-cycle core. It owns the program counter and drives the instruction-memory read address. The memory returns the word combinationally in the same cycle. The block captures {pc, instruction} pairs into a 2-entry skid buffer and presents them downstream to decode through a valid/ready handshake. It handles stalls, control-flow redirects and a post-reset boot wait.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BOOT_CYCLES, 1, cycles after reset release before the first fetch. This lets instruction memory finish loading. 0 means fetch starts immediately.

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous and active-high
- imem_addr  out  32  read address to instruction memory; always equals pc
- imem_data  in  32  instruction word for imem_addr, valid the same cycle
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  32  new PC; bits [1:0] ignored (forced 00)
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode accepts head entry
- out_instr  out  32  head entry instruction
- out_pc  out  32  head entry PC

## Operation
- State: pc (32), buffer of 2 entries {pc, instr}, count (0..2), FSM {BOOT, RUN}, boot counter.
- Reset values:
  - pc = RESET_PC
  - count = 0
  - all entries = 0
  - FSM = BOOT with counter = BOOT_CYCLES, or RUN if BOOT_CYCLES = 0
  - resulting outputs: out_valid = 0, out_instr = 0, out_pc = 0, imem_addr = RESET_PC
- BOOT:
  - No fetch happens.
  - The counter decrements each cycle. The FSM moves to RUN on the edge where the counter reaches 0.
  - A redirect during BOOT updates pc only; the counter is unaffected.
- pop = out_valid && out_ready.
- fetch = (FSM == RUN) && !redirect_valid && (count < 2 || pop).
- On fetch:
  - The entry {pc, imem_data} is pushed at the tail.
  - pc <= pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
- On pop: the head is removed and the next entry becomes the head.
- Simultaneous push and pop: count is unchanged and order is preserved.
- Full (count == 2) without pop: no fetch, pc holds, imem_addr holds.
- Redirect (priority over everything except rst):
  - The buffer is cleared (count <= 0). A pop in the same cycle still counts as delivered.
  - pc <= {redirect_target[31:2], 2'b00}. There is no push that cycle.
- out_valid = (count != 0). out_instr and out_pc come from registers, with no combinational path from imem_data.
- Once out_valid is high, out_instr and out_pc stay stable until pop, redirect or rst.
- Reset mid-operation: all buffered entries are discarded and the reset values apply on the next edge.

## Timing
- Fetch-to-output latency is 1 cycle: a word fetched in cycle N is visible on out_* in cycle N+1.
- Throughput is 1 instruction/cycle while out_ready stays high.
- After rst deasserts, the first out_valid comes BOOT_CYCLES + 1 cycles later, with out_pc = RESET_PC.
- Redirect asserted in cycle N:
  - out_valid = 0 in cycle N+1.
  - imem_addr = target in cycle N+1.
  - The target instruction appears on out_* in cycle N+2.
- Stall: if out_ready drops with an empty buffer, the buffer fills to 2 after two cycles and pc then freezes. When out_ready rises, pop and fetch happen in the same cycle with no bubble.
- redirect_valid and rst are sampled only at the clock edge. A redirect in the same cycle as rst is ignored.

## Test plan
- Reset and boot:
  - Stimulus: bench imem returns 32'hA000_0000 | addr; BOOT_CYCLES = 1; out_ready = 1.
  - Required response: out_valid first high 2 cycles after rst release; out_pc sequence 0, 4, 8, 12 with out_instr = A000_0000, A000_0004, … on consecutive cycles.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles starting when out_pc = 8.
  - Required response: count saturates at 2 (holding 8 and 12); imem_addr holds at 16; out_pc stays 8. On out_ready = 1 the sequence continues 8, 12, 16 with no gap and no duplicate.
- Redirect:
  - Stimulus: assert redirect_valid with target 32'h0000_0027 while out_pc = 4.
  - Required response: next cycle out_valid = 0 and imem_addr = 32'h24; the cycle after, out_pc = 32'h24, then 32'h28. Entry 4 is delivered only if popped in the redirect cycle.
- Redirect while full and stalled:
  - Stimulus: out_ready = 0, count = 2, then redirect to 32'h40.
  - Required response: buffer cleared, no stale entry ever delivered, first delivered out_pc = 32'h40.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFF8.
  - Required response: delivered out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset mid-stream:
  - Stimulus: rst pulsed for 1 cycle while count = 2 and a redirect is asserted in the same cycle.
  - Required response: out_valid = 0, out_pc = 0, imem_addr = RESET_PC after the edge; fetch restarts from RESET_PC after BOOT_CYCLES; the redirect is ignored.
